// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and symbol helper for the rate-1/2, K=4
// convolutional encoder and the matching branch-metric logic.
package conv_pkg;

  localparam int K            = 4;
  localparam int NSTATES      = 8;
  localparam int TAIL_LEN     = 3;
  localparam int MAX_DATA_DEF = 1021;

  localparam logic [3:0] G0_DEF = 4'b1101;
  localparam logic [3:0] G1_DEF = 4'b1111;

  typedef enum logic {DATA, TAIL} enc_state_t;

  // Tap vector is {b, sr[2], sr[1], sr[0]}; result is {c1, c0}.
  function automatic logic [1:0] conv_sym(input logic [3:0] v);
    return {^(v & G0_DEF), ^(v & G1_DEF)};
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Combinational trellis step: code symbol and next shift-register state for
// one input bit.
import conv_pkg::*;

module conv_enc_core #(
  parameter logic [3:0] G0 = G0_DEF,
  parameter logic [3:0] G1 = G1_DEF
) (
  input  logic         i_bit,
  input  logic [K-2:0] i_sr,
  output logic [1:0]   o_sym,
  output logic [K-2:0] o_sr_next
);

  logic [K-1:0] w_v;

  assign w_v       = {i_bit, i_sr};
  assign o_sym     = {^(w_v & G0), ^(w_v & G1)};
  // The newest bit enters at the top so states 0 and 1 share successors.
  assign o_sr_next = {i_bit, i_sr[K-2:1]};

endmodule

// File: rtl/conv_encoder.sv
// Framed rate-1/2 convolutional encoder with valid/ready handshakes and
// automatic zero-tail termination back to state 000.
import conv_pkg::*;

module conv_encoder #(
  parameter logic [3:0] G0       = G0_DEF,
  parameter logic [3:0] G1       = G1_DEF,
  parameter int         MAX_DATA = MAX_DATA_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  input  logic       i_in_bit,
  input  logic       i_in_last,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic [1:0] o_out_sym,
  output logic       o_out_last,
  output logic       o_frame_trunc
);

  enc_state_t   r_state;
  logic [K-2:0] r_sr;
  logic [9:0]   r_data_cnt;
  logic [1:0]   r_tail_cnt;
  logic         r_out_valid;
  logic [1:0]   r_out_sym;
  logic         r_out_last;
  logic         r_frame_trunc;

  logic         w_can_launch;
  logic         w_accept;
  logic         w_tail_fire;
  logic         w_tail_done;
  logic         w_core_bit;
  logic [1:0]   w_sym;
  logic [K-2:0] w_sr_next;
  logic [9:0]   w_cnt_inc;
  logic         w_hit_max;

  // The output register is free when empty or being drained this cycle.
  assign w_can_launch = !r_out_valid || i_out_ready;
  assign o_in_ready   = (r_state == DATA) && w_can_launch;
  assign w_accept     = i_in_valid && o_in_ready;
  assign w_tail_fire  = (r_state == TAIL) && w_can_launch;
  assign w_tail_done  = (r_tail_cnt == 2'(TAIL_LEN - 1));
  assign w_core_bit   = (r_state == DATA) && i_in_bit;
  assign w_cnt_inc    = r_data_cnt + 10'd1;
  assign w_hit_max    = (w_cnt_inc == 10'(MAX_DATA));

  conv_enc_core #(.G0(G0), .G1(G1)) u_core (
    .i_bit     (w_core_bit),
    .i_sr      (r_sr),
    .o_sym     (w_sym),
    .o_sr_next (w_sr_next)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst || !i_enable) begin
      r_state       <= DATA;
      r_sr          <= '0;
      r_data_cnt    <= '0;
      r_tail_cnt    <= '0;
      r_out_valid   <= 1'b0;
      r_out_sym     <= 2'b00;
      r_out_last    <= 1'b0;
      r_frame_trunc <= 1'b0;
    end else begin
      if (w_can_launch) begin
        r_out_valid <= w_accept || w_tail_fire;
        if (w_accept || w_tail_fire) begin
          r_out_sym  <= w_sym;
          r_out_last <= w_tail_fire && w_tail_done;
          r_sr       <= w_sr_next;
        end
      end

      if (w_accept) begin
        r_data_cnt <= w_cnt_inc;
        if (i_in_last || w_hit_max) begin
          r_state    <= TAIL;
          r_tail_cnt <= '0;
        end
        // A frame that ends exactly at the limit with in_last is not truncated.
        if (!i_in_last && w_hit_max) begin
          r_frame_trunc <= 1'b1;
        end
      end

      if (w_tail_fire) begin
        if (w_tail_done) begin
          r_state    <= DATA;
          r_data_cnt <= '0;
          r_tail_cnt <= '0;
        end else begin
          r_tail_cnt <= r_tail_cnt + 2'd1;
        end
      end
    end
  end

  assign o_out_valid   = r_out_valid;
  assign o_out_sym     = r_out_sym;
  assign o_out_last    = r_out_last;
  assign o_frame_trunc = r_frame_trunc;

endmodule

// File: tb/tb_conv_encoder.sv
// Bench for conv_encoder: hand-computed vector tables for short frames plus
// random frames checked against a convolution model of the generators.
module tb_conv_encoder;

  localparam int MAX_DATA = 1021;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       inValid;
  logic       inReady;
  logic       inBit;
  logic       inLast;
  logic       outValid;
  logic       outReady = 1'b1;
  logic [1:0] outSym;
  logic       outLast;
  logic       frameTrunc;

  int   vecCount  = 0;
  int   missCount = 0;
  logic readyMode = 1'b0;
  logic monEnable = 1'b0;
  logic stallHeld = 1'b0;
  logic [1:0] heldSym;
  logic       heldLast;

  typedef struct {
    logic       bitIn;
    logic       lastIn;
    logic       isTail;
    logic [1:0] sym;
    logic       symLast;
  } vec_t;

  vec_t       tbl[$];
  bit         hist[$];
  logic [2:0] expQ[$];
  bit         frameBits[$];

  conv_encoder dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_enable      (enable),
    .i_in_valid    (inValid),
    .o_in_ready    (inReady),
    .i_in_bit      (inBit),
    .i_in_last     (inLast),
    .o_out_valid   (outValid),
    .i_out_ready   (outReady),
    .o_out_sym     (outSym),
    .o_out_last    (outLast),
    .o_frame_trunc (frameTrunc)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      outReady = readyMode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Encoder output as a convolution of the frame bits with G0=1101, G1=1111.
  function automatic bit uAt(int k);
    return (k >= 0 && k < hist.size()) ? hist[k] : 1'b0;
  endfunction

  function automatic logic [1:0] symAt(int i);
    logic c1, c0;
    c1 = uAt(i) ^ uAt(i-1) ^ uAt(i-3);
    c0 = uAt(i) ^ uAt(i-1) ^ uAt(i-2) ^ uAt(i-3);
    return {c1, c0};
  endfunction

  task automatic modelAccept(input bit b, input bit last);
    hist.push_back(b);
    expQ.push_back({symAt(hist.size() - 1), 1'b0});
    if (last || hist.size() == MAX_DATA) begin
      for (int t = 0; t < 3; t++) begin
        hist.push_back(1'b0);
        expQ.push_back({symAt(hist.size() - 1), 1'(t == 2)});
      end
      hist.delete();
    end
  endtask

  always @(negedge clk) begin
    if (monEnable) begin
      if (outValid && !outReady) begin
        checkOutput("stall_in_ready", inReady, 0);
        if (stallHeld) begin
          checkOutput("stall_sym_hold", {outSym, outLast}, {heldSym, heldLast});
        end
        stallHeld = 1'b1;
        heldSym   = outSym;
        heldLast  = outLast;
      end else begin
        stallHeld = 1'b0;
      end
      if (outValid && outReady) begin
        if (expQ.size() == 0) begin
          checkOutput("extra_symbol", {outSym, outLast}, 32'hFFFF);
        end else begin
          checkOutput("stream_sym", {outSym, outLast}, expQ.pop_front());
        end
      end
    end
  end

  // Offers one bit until accepted; the model is updated on the accepting cycle.
  task automatic applyStimulus(input bit b, input bit last);
    bit done = 1'b0;
    inValid = 1'b1;
    inBit   = b;
    inLast  = last;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (inReady) begin
        modelAccept(b, last);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    inValid = 1'b0;
    inLast  = 1'b0;
    if (!done) checkOutput("accept_timeout", done, 1);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 400 && expQ.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("drain_empty", expQ.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic addRow(input logic b, input logic l, input logic t, input logic [1:0] s, input logic sl);
    tbl.push_back('{bitIn: b, lastIn: l, isTail: t, sym: s, symLast: sl});
  endtask

  task automatic runTable();
    for (int r = 0; r < tbl.size(); r++) begin
      inValid = !tbl[r].isTail;
      inBit   = tbl[r].bitIn;
      inLast  = tbl[r].lastIn;
      @(negedge clk);
      checkOutput("tbl_in_ready", inReady, !tbl[r].isTail);
      @(posedge clk);
      #1;
      checkOutput("tbl_valid", outValid, 1);
      checkOutput("tbl_sym", outSym, tbl[r].sym);
      checkOutput("tbl_last", outLast, tbl[r].symLast);
    end
    inValid = 1'b0;
    inLast  = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("tbl_idle_valid", outValid, 0);
    checkOutput("tbl_idle_ready", inReady, 1);
  endtask

  task automatic sendRandomFrame(input int len, input bit withLast);
    for (int i = 0; i < len; i++) applyStimulus(1'($urandom_range(0, 1)), withLast && (i == len - 1));
  endtask

  initial begin
    rst     = 1'b0;
    enable  = 1'b1;
    inValid = 1'b0;
    inBit   = 1'b0;
    inLast  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", outValid, 0);
    checkOutput("reset_sym", outSym, 0);
    checkOutput("reset_last", outLast, 0);
    checkOutput("reset_trunc", frameTrunc, 0);
    checkOutput("reset_in_ready", inReady, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Frame 1,0,1,1,0,0,1,0 then three tail symbols.
    addRow(1, 0, 0, 2'b11, 0);
    addRow(0, 0, 0, 2'b11, 0);
    addRow(1, 0, 0, 2'b10, 0);
    addRow(1, 0, 0, 2'b11, 0);
    addRow(0, 0, 0, 2'b10, 0);
    addRow(0, 0, 0, 2'b10, 0);
    addRow(1, 0, 0, 2'b00, 0);
    addRow(0, 1, 0, 2'b11, 0);
    addRow(0, 0, 1, 2'b01, 0);
    addRow(0, 0, 1, 2'b11, 0);
    addRow(0, 0, 1, 2'b00, 1);
    runTable();

    // Same 20-bit frame without and with random backpressure.
    monEnable = 1'b1;
    for (int i = 0; i < 20; i++) frameBits.push_back(1'($urandom_range(0, 1)));
    for (int pass = 0; pass < 2; pass++) begin
      readyMode = 1'(pass);
      for (int i = 0; i < 20; i++) applyStimulus(frameBits[i], i == 19);
      waitDrain();
    end

    sendRandomFrame(1, 1'b1);
    sendRandomFrame($urandom_range(2, 60), 1'b1);
    sendRandomFrame($urandom_range(2, 60), 1'b1);
    sendRandomFrame(MAX_DATA, 1'b1);
    waitDrain();
    checkOutput("exact_max_no_trunc", frameTrunc, 0);

    // 1022 bits without in_last before the last one: truncation, then a 1-bit frame.
    sendRandomFrame(MAX_DATA + 1, 1'b1);
    waitDrain();
    checkOutput("trunc_sticky", frameTrunc, 1);

    sendRandomFrame(5, 1'b0);
    monEnable = 1'b0;
    enable    = 1'b0;
    @(posedge clk);
    #1;
    enable = 1'b1;
    expQ.delete();
    hist.delete();
    stallHeld = 1'b0;
    checkOutput("enable_flush_valid", outValid, 0);
    checkOutput("enable_flush_trunc", frameTrunc, 0);
    checkOutput("enable_flush_ready", inReady, 1);
    monEnable = 1'b1;
    readyMode = 1'b0;
    sendRandomFrame(12, 1'b1);
    waitDrain();
    monEnable = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset right after the first tail symbol of frame {1,0}.
    inValid = 1'b1;
    inBit   = 1'b1;
    inLast  = 1'b0;
    @(posedge clk);
    #1;
    inBit  = 1'b0;
    inLast = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    inLast  = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midtail_valid", outValid, 1);
    checkOutput("midtail_sym", outSym, 2'b01);
    checkOutput("midtail_in_ready", inReady, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    checkOutput("midtail_reset_valid", outValid, 0);
    checkOutput("midtail_reset_ready", inReady, 1);

    tbl.delete();
    addRow(1, 1, 0, 2'b11, 0);
    addRow(0, 0, 1, 2'b11, 0);
    addRow(0, 0, 1, 2'b01, 0);
    addRow(0, 0, 1, 2'b11, 1);
    runTable();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/conv_encoder.md
Name: conv_encoder

Overview:
- Rate-1/2, constraint-length-4 (8-state) convolutional encoder; transmit-side counterpart of the Viterbi decoder.
- Accepts a framed serial bit stream through a valid/ready handshake and emits one 2-bit code symbol per accepted bit.
- At the end of each frame it appends K-1 = 3 zero tail bits, returning the trellis to state 000 so the decoder's traceback starts from a known state.
- Output feeds the channel model / decoder d_in in the test harness.

Parameters:
- G0, 4'b1101, generator polynomial for sym[1]; bit 3 taps the input bit, bits 2..0 tap sr[2..0].
- G1, 4'b1111, generator polynomial for sym[0], same bit ordering.
- MAX_DATA, 1021, maximum data bits per frame (1021 data + 3 tail = 1024 symbols, one trellis memory bank).

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, reset; synchronous, active-low.
- enable, in, 1, low = synchronous flush to the reset state (same effect as rst).
- in_valid, in, 1, in_bit/in_last are valid.
- in_ready, out, 1, encoder accepts the input this cycle.
- in_bit, in, 1, data bit.
- in_last, in, 1, marks the final data bit of a frame.
- out_valid, out, 1, out_sym is valid.
- out_ready, in, 1, downstream accepts out_sym.
- out_sym, out, 2, code symbol {c1,c0}; bit 1 is from G0, bit 0 is from G1.
- out_last, out, 1, final tail symbol of the frame.
- frame_trunc, out, 1, sticky; a frame hit MAX_DATA without in_last.

Behaviour:
- Reset (rst==0 or enable==0 at a clk edge) sets:
  - sr=3'b000, fsm=DATA, data_cnt=0, tail_cnt=0.
  - out_valid=0, out_sym=2'b00, out_last=0, frame_trunc=0.
- in_ready is combinational and must not depend on in_valid: in_ready = (fsm==DATA) && (!out_valid || out_ready).
- Shift register and symbol computation:
  - State sr[2:0]; the tap vector is v = {b, sr[2], sr[1], sr[0]}, where b is the input bit.
  - c1 = ^(v & G0); c0 = ^(v & G1).
  - Next state sr <= {b, sr[2:1]}, so states 0 and 1 both lead to 000 (b=0) or 100 (b=1), matching the decoder's ACS wiring.
- Output stage is a single register:
  - A symbol is launched when the fsm produces one and (!out_valid || out_ready).
  - Latency: input accepted at edge N, so out_valid=1 with its symbol after edge N.
  - Full throughput: one symbol per clock while out_ready==1.
  - With out_valid==1 and out_ready==0, out_sym and out_last are held and sr does not advance.
- FSM DATA:
  - On each accepted bit: emit the symbol, update sr, data_cnt++.
  - Move to TAIL (tail_cnt=0) when an accepted bit has in_last==1, or when the accepted bit makes data_cnt==MAX_DATA.
  - In the MAX_DATA case, set frame_trunc=1; the next bit then starts a new frame.
- FSM TAIL:
  - in_ready=0. Whenever the output stage can accept, emit the symbol for b=0, shift sr, tail_cnt++.
  - The 3rd tail symbol carries out_last=1. The fsm then returns to DATA with data_cnt=0; sr is already 000 by construction.
- Boundary cases:
  - Single-bit frame (in_last on the first bit): 1 data symbol + 3 tail symbols.
  - in_last coinciding with data_cnt reaching MAX_DATA: normal termination; frame_trunc is not set.
  - Reset or enable low mid-TAIL or mid-stall: the pending symbol is discarded and out_valid drops on the next cycle.
  - frame_trunc clears only on reset or enable low.
  - in_valid while in_ready==0 is ignored; the source must hold its data.
- Counters and widths:
  - data_cnt is 10 bits, compared against MAX_DATA.
  - tail_cnt is 2 bits and never wraps past 2.

Decomposition:
- Package conv_pkg holds:
  - K=4, NSTATES=8, TAIL_LEN=3.
  - Default G0/G1 constants, shared with the bmc modules.
  - typedef enum logic {DATA, TAIL} enc_state_t.
  - A function conv_sym(input logic [3:0] v) returning the 2-bit symbol.
- Sub-module conv_enc_core: combinational symbol plus next-state computation.
- The top level holds the FSM, counters and output register.

Test Plan:
- Frame of 8 bits 1,0,1,1,0,0,1,0 with in_last on the 8th, out_ready=1:
  - Requires exactly 11 symbols, out_last on the 11th only, and sr==000 afterwards.
  - First symbols: b=1 gives 11, b=0 (sr=100) gives 11, b=1 (sr=010) gives 10.
- Loopback: 3 frames of 1021 random bits through conv_encoder into the Viterbi decoder with no noise:
  - Decoded bits must equal the source bits after decoder latency.
- Backpressure:
  - Toggle out_ready randomly (50%) during a 20-bit frame.
  - The symbol sequence must be identical to the out_ready=1 run; out_sym is stable while out_valid && !out_ready; no input is accepted during stalls.
- Truncation: 1022 bits with no in_last.
  - After the 1021st bit, in_ready=0 for 3 tail symbols and frame_trunc=1.
  - The 1022nd bit starts a new frame, encoded from sr=000.
- Reset mid-tail:
  - Assert rst=0 for one cycle after the 1st tail symbol: the next cycle has out_valid=0 and in_ready=1.
  - Then send a frame {1} with in_last: symbols 11,11,01,11.
- enable low for 1 cycle mid-frame:
  - Same flush as reset; frame_trunc clears; the next accepted bit encodes from sr=000.
